// File: rtl/sinc3_norm.sv
// Normalises a raw unsigned sinc3 result to a signed fraction of full scale (osr+1)^3.
// Sequential: 20-cycle latency for OUT_WIDTH=16. An input that arrives while busy is dropped and sets overrun.
module sinc3_norm #(
  parameter int OSR_WIDTH = 16,
  parameter int OUT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   sclr,
  input  logic [OSR_WIDTH-1:0]   osr,
  input  logic [3*OSR_WIDTH-1:0] in_data,
  input  logic                   in_valid,
  output logic [OUT_WIDTH-1:0]   out_data,
  output logic                   out_valid,
  output logic                   busy,
  output logic                   overrun
);
  localparam int XW  = 3*OSR_WIDTH;
  localparam int NW  = OSR_WIDTH + 1;
  localparam int N2W = 2*NW;
  localparam int FW  = 3*OSR_WIDTH + 3;
  localparam int RW  = FW + 1;
  localparam int CW  = $clog2(OUT_WIDTH);

  typedef enum logic [2:0] {S_IDLE, S_FS1, S_FS2, S_PREP, S_DIV, S_DONE} state_t;

  state_t               r_state, w_next;
  logic [XW-1:0]        r_x;
  logic [NW-1:0]        r_n;
  logic [N2W-1:0]       r_n2;
  logic [FW-1:0]        r_fs;
  logic [RW-1:0]        r_rem;
  logic [OUT_WIDTH-1:0] r_q;
  logic [CW-1:0]        r_cnt;
  logic                 r_sign;
  logic [OUT_WIDTH-1:0] r_out;
  logic                 r_overrun;

  logic                 w_accept, w_busy, w_done, w_last;
  logic [RW-1:0]        w_fs_ext, w_x_ext, w_xc, w_2x, w_mag, w_rem_sub;
  logic                 w_sign, w_ge;
  logic [OUT_WIDTH-1:0] w_q_next, w_result;

  assign w_last = (r_cnt == CW'(OUT_WIDTH-1));

  always_ff @(posedge clock) begin
    if (sclr) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_busy   = 1'b0;
    w_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = S_FS1;
        end
      end
      S_FS1: begin
        w_busy = 1'b1;
        w_next = S_FS2;
      end
      S_FS2: begin
        w_busy = 1'b1;
        w_next = S_PREP;
      end
      S_PREP: begin
        w_busy = 1'b1;
        w_next = S_DIV;
      end
      S_DIV: begin
        w_busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = S_FS1;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Map x in [0, FS] onto the signed magnitude of 2x - FS.
  assign w_fs_ext = {1'b0, r_fs};
  assign w_x_ext  = {{(RW-XW){1'b0}}, r_x};
  assign w_xc     = (w_x_ext > w_fs_ext) ? w_fs_ext : w_x_ext;
  assign w_2x     = w_xc << 1;
  assign w_sign   = (w_2x < w_fs_ext);
  assign w_mag    = w_sign ? (w_fs_ext - w_2x) : (w_2x - w_fs_ext);

  // Remainder starts at mag (dividend scaled by 2^(OUT_WIDTH-1) is implied by the shift count).
  assign w_ge      = (r_rem >= w_fs_ext);
  assign w_rem_sub = w_ge ? (r_rem - w_fs_ext) : r_rem;
  assign w_q_next  = (r_q << 1) | OUT_WIDTH'(w_ge);

  always_comb begin
    if (r_sign)                      w_result = -w_q_next;
    else if (w_q_next[OUT_WIDTH-1])  w_result = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    else                             w_result = w_q_next;
  end

  always_ff @(posedge clock) begin
    if (sclr) begin
      r_x       <= '0;
      r_n       <= '0;
      r_n2      <= '0;
      r_fs      <= '0;
      r_rem     <= '0;
      r_q       <= '0;
      r_cnt     <= '0;
      r_sign    <= 1'b0;
      r_out     <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_accept) begin
        r_x <= in_data;
        r_n <= NW'(osr) + NW'(1);
      end
      if (in_valid && w_busy) r_overrun <= 1'b1;
      case (r_state)
        S_FS1:  r_n2 <= N2W'(r_n) * N2W'(r_n);
        S_FS2:  r_fs <= FW'(r_n2) * FW'(r_n);
        S_PREP: begin
          r_rem  <= w_mag;
          r_sign <= w_sign;
          r_q    <= '0;
          r_cnt  <= '0;
        end
        S_DIV: begin
          r_rem <= w_rem_sub << 1;
          r_q   <= w_q_next;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) r_out <= w_result;
        end
        default: ;
      endcase
    end
  end

  assign out_data  = r_out;
  assign out_valid = w_done;
  assign busy      = w_busy;
  assign overrun   = r_overrun;
endmodule

// File: tb/tb_sinc3_norm.sv
// Directed bench for sinc3_norm: per-cycle scoreboard of out_valid/out_data/busy/overrun against an arithmetic model.
module tb_sinc3_norm;
  logic        clock = 1'b0;
  logic        sclr = 1'b1;
  logic [15:0] osr = 16'd399;
  logic [47:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic [15:0] out_data;
  logic        out_valid, busy, overrun;

  sinc3_norm #(.OSR_WIDTH(16), .OUT_WIDTH(16)) dut (
    .clock(clock), .sclr(sclr), .osr(osr), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc = cyc + 1;

  int checks = 0;
  int errors = 0;

  // Scoreboard and expected-state model
  int          q_due[$];
  logic [15:0] q_val[$];
  logic [15:0] q_lit[$];
  bit          q_has[$];
  int          ka = -100;
  bit          ov_set = 0;
  int          ov_cyc = 0;
  logic [15:0] exp_out = '0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_norm(input longint unsigned x, input int unsigned o);
    longint unsigned n, fs, xc, mag, q;
    bit neg;
    n   = longint'(o) + 1;
    fs  = n * n * n;
    xc  = (x > fs) ? fs : x;
    neg = (2 * xc < fs);
    mag = neg ? (fs - 2 * xc) : (2 * xc - fs);
    q   = (mag * 32768) / fs;
    if (neg) return 16'(-int'(q));
    if (q == 32768) return 16'h7fff;
    return 16'(q);
  endfunction

  always @(negedge clock) begin
    if (!sclr) begin
      if (q_due.size() > 0 && q_due[0] == cyc) begin
        chk("out_valid_pulse", out_valid, 1);
        exp_out = q_val[0];
        if (q_has[0]) chk("out_data_literal", out_data, q_lit[0]);
        void'(q_due.pop_front());
        void'(q_val.pop_front());
        void'(q_lit.pop_front());
        void'(q_has.pop_front());
      end else begin
        chk("out_valid_idle", out_valid, 0);
      end
      chk("out_data", out_data, exp_out);
      chk("busy", busy, (cyc >= ka + 1 && cyc <= ka + 19) ? 1 : 0);
      chk("overrun", overrun, (ov_set && cyc >= ov_cyc) ? 1 : 0);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // One-cycle in_valid strobe; has_lit selects a hand-computed expectation as well.
  task automatic send(input longint unsigned x, input int unsigned o, input bit has_lit, input logic [15:0] lit);
    in_data  = 48'(x);
    osr      = 16'(o);
    in_valid = 1'b1;
    if (cyc < ka + 20) begin
      if (!ov_set) begin
        ov_set = 1;
        ov_cyc = cyc + 1;
      end
    end else begin
      ka = cyc;
      q_due.push_back(cyc + 20);
      q_val.push_back(ref_norm(x, o));
      q_lit.push_back(lit);
      q_has.push_back(has_lit);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    sclr = 1'b1;
    q_due.delete();
    q_val.delete();
    q_lit.delete();
    q_has.delete();
    ka = -100;
    ov_set = 0;
    exp_out = '0;
    tick();
    sclr = 1'b0;
  endtask

  initial begin
    idle(3);
    sclr = 1'b0;
    idle(3);

    // Mid-scale, extremes, clamp, truncation
    send(32000000, 399, 1, 16'h0000); idle(25);
    send(0,        399, 1, 16'h8000); idle(25);
    send(64000000, 399, 1, 16'h7fff); idle(25);
    send(70000000, 399, 1, 16'h7fff); idle(25);
    send(48000000, 399, 1, 16'h4000); idle(25);
    send(16000001, 399, 1, 16'hc001); idle(25);
    for (int i = 0; i < 6; i++) begin
      send(longint'($urandom_range(70000000, 0)), 399, 0, 16'h0000);
      idle(25);
    end

    // Back-to-back: second strobe lands in the DONE cycle
    send(24000000, 399, 1, 16'he000); idle(19);
    send(40000000, 399, 1, 16'h2000); idle(25);

    // Overrun: FS=1000, strobe every 10 cycles, odd ones dropped
    send(750,  9, 1, 16'h4000); idle(9);
    send(250,  9, 1, 16'hc000); idle(9);
    send(1000, 9, 1, 16'h7fff); idle(9);
    send(0,    9, 1, 16'h8000); idle(9);
    send(900,  9, 1, 16'd26214); idle(9);
    send(500,  9, 1, 16'h0000); idle(30);

    // Reset 8 cycles after accept, then normal conversion
    osr = 16'd399;
    send(48000000, 399, 1, 16'h4000); idle(7);
    do_reset();
    idle(25);
    send(48000000, 399, 1, 16'h4000); idle(25);

    // osr switched during DIV is ignored until the next accept
    send(16000001, 399, 1, 16'hc001); idle(8);
    osr = 16'd99;
    idle(20);
    send(500000, 99, 1, 16'h0000); idle(25);
    send(750000, 99, 1, 16'h4000); idle(25);

    chk("results_pending", q_due.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
